// File: rtl/alu_op_encoder_pkg.sv
// Shared definitions for the ALU operation encoder: ALU codes, RV opcodes,
// operand-select encodings and the decoded control bundle.
package alu_op_encoder_pkg;

    // ALU codes; must stay in lock-step with the ALU's own decode.
    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_LINK = 6'd1;
    localparam logic [5:0] ALU_EQ   = 6'd2;
    localparam logic [5:0] ALU_NE   = 6'd3;
    localparam logic [5:0] ALU_LT   = 6'd4;
    localparam logic [5:0] ALU_GE   = 6'd5;
    localparam logic [5:0] ALU_LTU  = 6'd6;
    localparam logic [5:0] ALU_GEU  = 6'd7;
    localparam logic [5:0] ALU_XOR  = 6'd8;
    localparam logic [5:0] ALU_OR   = 6'd9;
    localparam logic [5:0] ALU_AND  = 6'd10;
    localparam logic [5:0] ALU_SLL  = 6'd11;
    localparam logic [5:0] ALU_SRL  = 6'd12;
    localparam logic [5:0] ALU_SRA  = 6'd13;
    localparam logic [5:0] ALU_SUB  = 6'd14;
    localparam logic [5:0] ALU_ADDW = 6'd15;
    localparam logic [5:0] ALU_SLLW = 6'd16;
    localparam logic [5:0] ALU_SRLW = 6'd17;
    localparam logic [5:0] ALU_SRAW = 6'd18;
    localparam logic [5:0] ALU_SUBW = 6'd19;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2,
        A_SEL_PC4  = 2'd3
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

    typedef struct packed {
        logic [5:0] op;
        a_sel_e     a_sel;
        b_sel_e     b_sel;
        logic       branch;
        logic       jump;
        logic       illegal;
    } alu_ctrl_t;

    localparam int ALU_CTRL_W = $bits(alu_ctrl_t);

    // Integer ALU code shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [5:0] int_op(input logic [2:0] funct3, input logic alt);
        logic [5:0] code;
        code = ALU_ADD;
        unique case (funct3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_LT;
            3'b011:  code = ALU_LTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Pure combinational decode of a raw RV32I/RV64I instruction word into the
// ALU control bundle. Any illegal encoding collapses to the illegal-only bundle.
module alu_op_decode_comb
    import alu_op_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr_i,
    output logic [ALU_CTRL_W-1:0] ctrl_o
);

    localparam bit RV64 = (DATA_WIDTH == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift_imm;
    logic       shift_imm_bad;
    alu_ctrl_t  ctrl;
    logic       ill;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register and immediate fields are irrelevant to the ALU code.
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    assign is_shift_imm  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign shift_imm_bad = ((instr_i[31:26] != 6'b000000) && (instr_i[31:26] != 6'b010000))
                         || (instr_i[30] && (funct3 == 3'b001))
                         || (instr_i[25] && !RV64);

    always_comb begin
        ctrl = '0;
        ill  = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_STORE: begin
                ctrl.b_sel = B_SEL_IMM;
            end
            OPC_LUI: begin
                ctrl.a_sel = A_SEL_ZERO;
                ctrl.b_sel = B_SEL_IMM;
            end
            OPC_AUIPC: begin
                ctrl.a_sel = A_SEL_PC;
                ctrl.b_sel = B_SEL_IMM;
            end
            OPC_JAL: begin
                ctrl.op    = ALU_LINK;
                ctrl.a_sel = A_SEL_PC4;
                ctrl.jump  = 1'b1;
            end
            OPC_JALR: begin
                ctrl.op    = ALU_LINK;
                ctrl.a_sel = A_SEL_PC4;
                ctrl.jump  = 1'b1;
                ill        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                unique case (funct3)
                    3'b000:  ctrl.op = ALU_EQ;
                    3'b001:  ctrl.op = ALU_NE;
                    3'b100:  ctrl.op = ALU_LT;
                    3'b101:  ctrl.op = ALU_GE;
                    3'b110:  ctrl.op = ALU_LTU;
                    3'b111:  ctrl.op = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                ctrl.op = int_op(funct3, instr_i[30]);
                if ((funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) begin
                    ill = 1'b1;
                end else if (instr_i[30] && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                    ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Non-shift immediates may freely set bit 30 (imm[10]).
                ctrl.b_sel = B_SEL_IMM;
                ctrl.op    = int_op(funct3, is_shift_imm && instr_i[30]);
                ill        = is_shift_imm && shift_imm_bad;
            end
            OPC_OP_32: begin
                ill = !RV64;
                unique case ({funct7, funct3})
                    {FUNCT7_BASE, 3'b000}: ctrl.op = ALU_ADDW;
                    {FUNCT7_ALT,  3'b000}: ctrl.op = ALU_SUBW;
                    {FUNCT7_BASE, 3'b001}: ctrl.op = ALU_SLLW;
                    {FUNCT7_BASE, 3'b101}: ctrl.op = ALU_SRLW;
                    {FUNCT7_ALT,  3'b101}: ctrl.op = ALU_SRAW;
                    default:               ill = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                ctrl.b_sel = B_SEL_IMM;
                ill        = !RV64;
                unique case (funct3)
                    3'b000: ctrl.op = ALU_ADDW;
                    3'b001: begin
                        ctrl.op = ALU_SLLW;
                        if (funct7 != FUNCT7_BASE) ill = 1'b1;
                    end
                    3'b101: begin
                        ctrl.op = instr_i[30] ? ALU_SRAW : ALU_SRLW;
                        if ((funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/alu_op_encoder.sv
// Registered ALU operation encoder: one-cycle decode with a primary output
// register and a skid register so upstream can stream under back-pressure.
module alu_op_encoder
    import alu_op_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instruction_valid,
    input  logic [31:0] instruction,
    output logic        instruction_ready,
    output logic        ALU_operation_valid,
    input  logic        ALU_operation_ready,
    output logic [5:0]  ALU_operation,
    output logic [1:0]  operand_A_select,
    output logic        operand_B_select,
    output logic        branch,
    output logic        jump,
    output logic        illegal
);

    alu_ctrl_t dec_ctrl;
    alu_ctrl_t pri_ctrl_q, pri_ctrl_d;
    alu_ctrl_t skid_ctrl_q, skid_ctrl_d;
    logic      pri_valid_q, pri_valid_d;
    logic      skid_valid_q, skid_valid_d;
    logic      in_fire;
    logic      out_fire;
    logic      pri_free;

    alu_op_decode_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr_i (instruction),
        .ctrl_o  (dec_ctrl)
    );

    assign in_fire  = instruction_valid && !skid_valid_q;
    assign out_fire = pri_valid_q && ALU_operation_ready;
    assign pri_free = !pri_valid_q || ALU_operation_ready;

    always_comb begin
        pri_valid_d  = pri_valid_q;
        pri_ctrl_d   = pri_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (skid_valid_q) begin
            // Input is blocked while the skid holds an entry, so only a drain matters.
            if (out_fire) begin
                pri_ctrl_d   = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (pri_free) begin
                pri_valid_d = 1'b1;
                pri_ctrl_d  = dec_ctrl;
            end else begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = dec_ctrl;
            end
        end else if (out_fire) begin
            pri_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pri_valid_q  <= 1'b0;
            pri_ctrl_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
        end else begin
            pri_valid_q  <= pri_valid_d;
            pri_ctrl_q   <= pri_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

    assign instruction_ready   = !skid_valid_q;
    assign ALU_operation_valid = pri_valid_q;
    assign ALU_operation       = pri_ctrl_q.op;
    assign operand_A_select    = pri_ctrl_q.a_sel;
    assign operand_B_select    = pri_ctrl_q.b_sel;
    assign branch              = pri_ctrl_q.branch;
    assign jump                = pri_ctrl_q.jump;
    assign illegal             = pri_ctrl_q.illegal;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed bench for alu_op_encoder: an RV64 instance checked field by field,
// plus an RV32 instance on the same stimulus checked for code and illegal.
module tb_alu_op_encoder;

    logic        clock;
    logic        reset;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic        out_ready;

    logic        d64_in_ready, d64_valid, d64_b, d64_br, d64_jp, d64_ill;
    logic [5:0]  d64_op;
    logic [1:0]  d64_a;
    logic        d32_in_ready, d32_valid, d32_b, d32_br, d32_jp, d32_ill;
    logic [5:0]  d32_op;
    logic [1:0]  d32_a;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_encoder #(.DATA_WIDTH(64)) dut64 (
        .clock               (clock),
        .reset               (reset),
        .instruction_valid   (instruction_valid),
        .instruction         (instruction),
        .instruction_ready   (d64_in_ready),
        .ALU_operation_valid (d64_valid),
        .ALU_operation_ready (out_ready),
        .ALU_operation       (d64_op),
        .operand_A_select    (d64_a),
        .operand_B_select    (d64_b),
        .branch              (d64_br),
        .jump                (d64_jp),
        .illegal             (d64_ill)
    );

    alu_op_encoder #(.DATA_WIDTH(32)) dut32 (
        .clock               (clock),
        .reset               (reset),
        .instruction_valid   (instruction_valid),
        .instruction         (instruction),
        .instruction_ready   (d32_in_ready),
        .ALU_operation_valid (d32_valid),
        .ALU_operation_ready (out_ready),
        .ALU_operation       (d32_op),
        .operand_A_select    (d32_a),
        .operand_B_select    (d32_b),
        .branch              (d32_br),
        .jump                (d32_jp),
        .illegal             (d32_ill)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [5:0] op,
                              input logic [1:0] a, input logic b, input logic br,
                              input logic jp, input logic ill);
        $display("txn %-10s valid=%0b op=%0d A=%0d B=%0d br=%0b jmp=%0b ill=%0b",
                 tag, d64_valid, d64_op, d64_a, d64_b, d64_br, d64_jp, d64_ill);
        check_eq({tag, ".valid"}, 32'(d64_valid), 32'(v));
        check_eq({tag, ".op"},    32'(d64_op),    32'(op));
        check_eq({tag, ".A"},     32'(d64_a),     32'(a));
        check_eq({tag, ".B"},     32'(d64_b),     32'(b));
        check_eq({tag, ".br"},    32'(d64_br),    32'(br));
        check_eq({tag, ".jmp"},   32'(d64_jp),    32'(jp));
        check_eq({tag, ".ill"},   32'(d64_ill),   32'(ill));
    endtask

    // Present one instruction with ready high; it is checked one cycle later.
    task automatic run_vec(input string tag, input logic [31:0] instr, input logic [5:0] op,
                           input logic [1:0] a, input logic b, input logic br, input logic jp,
                           input logic ill, input logic ill32);
        instruction_valid = 1'b1;
        instruction       = instr;
        @(negedge clock);
        expect_out(tag, 1'b1, op, a, b, br, jp, ill);
        check_eq({tag, ".rv32ill"}, 32'(d32_ill), 32'(ill32));
        check_eq({tag, ".rv32op"},  32'(d32_op),  ill32 ? 32'd0 : 32'(op));
    endtask

    initial begin
        reset             = 1'b1;
        instruction_valid = 1'b0;
        instruction       = 32'h0;
        out_ready         = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        expect_out("reset", 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.in_ready", 32'(d64_in_ready), 32'd1);

        // Back-to-back stream, ready held high
        run_vec("add",     32'h002081B3, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("sub",     32'h402081B3, 6'd14, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("srai",    32'h40335293, 6'd13, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("srli",    32'h00335293, 6'd12, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("bgeu",    32'h00007063, 6'd7,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("br_f010", 32'h00002063, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_vec("jalr_f1", 32'h00001067, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_vec("jalr",    32'h000000E7, 6'd1,  2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_vec("addw",    32'h003100BB, 6'd15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("sraw",    32'h4020D1BB, 6'd18, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("slli32",  32'h02031293, 6'd11, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("slli_b30",32'h40031293, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_vec("lui",     32'h123452B7, 6'd0,  2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("auipc",   32'h00000297, 6'd0,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("mul",     32'h022081B3, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_vec("rvc",     32'h00004501, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        instruction_valid = 1'b0;
        @(negedge clock);
        check_eq("drain.valid", 32'(d64_valid), 32'd0);

        // Back-pressure: three offered, two taken, then FIFO drain
        out_ready         = 1'b0;
        instruction_valid = 1'b1;
        instruction       = 32'h002081B3;
        @(negedge clock);
        expect_out("bp1", 1'b1, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bp1.in_ready", 32'(d64_in_ready), 32'd1);
        instruction = 32'h402081B3;
        @(negedge clock);
        expect_out("bp2", 1'b1, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bp2.in_ready", 32'(d64_in_ready), 32'd0);
        instruction = 32'h0020C1B3;
        @(negedge clock);
        expect_out("bp3", 1'b1, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bp3.in_ready", 32'(d64_in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clock);
        expect_out("bp_sub", 1'b1, 6'd14, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bp_sub.in_ready", 32'(d64_in_ready), 32'd1);
        @(negedge clock);
        expect_out("bp_xor", 1'b1, 6'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        instruction_valid = 1'b0;
        @(negedge clock);
        check_eq("bp_end.valid", 32'(d64_valid), 32'd0);

        // Reset with both entries occupied
        out_ready         = 1'b0;
        instruction_valid = 1'b1;
        instruction       = 32'h00007063;
        @(negedge clock);
        instruction = 32'h000000E7;
        @(negedge clock);
        check_eq("full.in_ready", 32'(d64_in_ready), 32'd0);
        instruction_valid = 1'b0;
        reset             = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        expect_out("rst_mid", 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid.in_ready", 32'(d64_in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_eq("rst_after.valid", 32'(d64_valid), 32'd0);
            check_eq("rst_after.v32",   32'(d32_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_encoder.md
Name: alu_op_encoder

Overview:
- Execute-side producer of the 6-bit ALU_operation code and operand-select controls consumed by the core ALU.
- Decodes a 32-bit RV32I/RV64I instruction word into code, operand selects, branch/jump flags and an illegal flag.
- Results are registered behind a valid/ready handshake, with a 2-entry skid buffer so upstream fetch/decode can stream one instruction per cycle under back-pressure.
- Sits between decode and the ALU in the base core pipeline.

Parameters:
- DATA_WIDTH, 32, datapath width. 32 selects RV32I and makes W-ops illegal; 64 selects RV64I.

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- instruction_valid  input  1  instruction word presented
- instruction  input  32  raw instruction word
- instruction_ready  output  1  encoder can accept this cycle
- ALU_operation_valid  output  1  encoded result presented
- ALU_operation_ready  input  1  downstream accepts the result
- ALU_operation  output  6  ALU code 0..19
- operand_A_select  output  2  0=rs1, 1=PC, 2=zero, 3=PC+4
- operand_B_select  output  1  0=rs2, 1=immediate
- branch  output  1  conditional branch; ALU result is the taken flag
- jump  output  1  JAL/JALR
- illegal  output  1  unsupported encoding

Behaviour:
- Transfers: input transfer = instruction_valid & instruction_ready; output transfer = ALU_operation_valid & ALU_operation_ready.
- Latency is 1 cycle. An input accepted at edge N is presented at N+1 when the output register is empty or draining.
- Output register (primary):
  - If the output is empty or draining, the accepted instruction loads directly into the primary register.
  - If the primary register is stalled (valid & !ready) and an input is accepted, the entry goes to the skid register.
- Skid register:
  - When the primary register drains, the skid entry moves to the primary register on the same edge.
  - instruction_ready = !skid_valid. It is registered and does not depend combinationally on ALU_operation_ready.
- Ordering: strict FIFO. No entry is dropped or duplicated. Simultaneous accept-and-drain with the skid register full cannot occur, because ready is low.
- Reset: ALU_operation_valid=0, skid_valid=0, instruction_ready=1 on the cycle after reset. All control outputs are 0 and ALU_operation=0. Reset mid-stream discards both entries.
- Outputs hold stable while valid & !ready.
- Code map by opcode:
  - LOAD, STORE: code 0, A=rs1, B=imm.
  - LUI: code 0, A=zero, B=imm.
  - AUIPC: code 0, A=PC, B=imm.
  - JAL: code 1, A=PC+4, jump=1.
  - JALR: code 1, A=PC+4, jump=1. Requires funct3=0, else illegal.
  - BRANCH by funct3: 000→2, 001→3, 100→4, 101→5, 110→6, 111→7, branch=1, B=rs2. funct3 010 and 011 are illegal.
  - OP / OP-IMM by funct3: 000 ADD/ADDI→0; 000 with funct7=0100000 (OP only)→14; 010→4; 011→6; 100→8; 110→9; 111→10; 001→11; 101→12, or 13 when instr[30]=1.
  - OP-IMM uses B=imm. OP uses B=rs2.
  - OP-32 / OP-IMM-32 (DATA_WIDTH=64 only): ADDW/ADDIW→15, SLLW→16, SRLW→17, SRAW→18, SUBW→19.
- Illegal encodings:
  - Flag illegal=1, ALU_operation=0, branch=0, jump=0. The entry still flows through the handshake.
  - Any opcode outside the set above is illegal.
  - OP with funct7 not in {0000000, 0100000} is illegal.
  - instr[30]=1 with funct3 other than 000 (OP) or 101 is illegal.
  - Shift-immediate with instr[25]=1 is illegal when DATA_WIDTH=32.
  - Shift-immediate with instr[31:26] not in {000000, 010000} is illegal.
  - W-ops when DATA_WIDTH=32 are illegal.
  - Instructions with instr[1:0]≠11 are illegal.

Decomposition:
- Shared package holds:
  - ALU code constants ALU_ADD=0 … ALU_SUBW=19, kept in lock-step with the ALU.
  - Opcode constants (LOAD 0000011, OP_IMM 0010011, AUIPC 0010111, OP_IMM_32 0011011, STORE 0100011, OP 0110011, LUI 0110111, OP_32 0111011, BRANCH 1100011, JALR 1100111, JAL 1101111).
  - Operand-select encodings.
- One sub-module: alu_op_decode_comb, a pure combinational instruction-to-control-bundle decoder. The top level owns only the primary/skid registers and the handshake.

Test Plan:
- Streaming, ready held at 1: inputs 0x002081B3 (ADD) then 0x402081B3 (SUB). Each result appears one cycle after acceptance, codes 0 then 14, B=0, illegal=0, with no bubble.
- 0x40335293 (SRAI x5,x6,3) → code 13, B=1, A=0. 0x00335293 → code 12.
- BGEU (opcode 1100011, funct3 111) → code 7, branch=1. JALR with funct3=001 → illegal=1, code 0.
- 0x003100BB (ADDW): DATA_WIDTH=64 → code 15. DATA_WIDTH=32 → illegal=1.
- Back-pressure: ALU_operation_ready=0 for 3 cycles while 3 instructions are offered.
  - Two are accepted, then instruction_ready=0 and outputs are stable.
  - When ready rises, outputs drain in order and instruction_ready returns to 1 one cycle later.
- Reset asserted with both entries full → next cycle valid=0, instruction_ready=1, and the old entries never emerge.
